// File: rtl/ctrl_pkg.sv
// Shared encodings for the hardwired control sequencer: FSM states, opcodes,
// datapath select codes and the control word driven onto the datapath.
package ctrl_pkg;

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        FETCH_H = 3'd1,
        FETCH_L = 3'd2,
        EXEC1   = 3'd3,
        EXEC2   = 3'd4,
        HALT    = 3'd5
    } state_t;

    localparam logic [3:0] OP_LDI = 4'h0;
    localparam logic [3:0] OP_LD  = 4'h1;
    localparam logic [3:0] OP_ST  = 4'h2;
    localparam logic [3:0] OP_MOV = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_NOT = 4'h9;
    localparam logic [3:0] OP_INC = 4'hA;
    localparam logic [3:0] OP_DEC = 4'hB;
    localparam logic [3:0] OP_BRA = 4'hC;
    localparam logic [3:0] OP_BEQ = 4'hD;
    localparam logic [3:0] OP_BNE = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] FUN_DEC   = 2'd0;
    localparam logic [1:0] FUN_INC   = 2'd1;
    localparam logic [1:0] FUN_LOAD  = 2'd2;
    localparam logic [1:0] FUN_CLEAR = 2'd3;

    localparam logic [3:0] ALU_PASS_A = 4'd0;
    localparam logic [3:0] ALU_PASS_B = 4'd1;
    localparam logic [3:0] ALU_NOT_A  = 4'd2;
    localparam logic [3:0] ALU_ADD    = 4'd4;
    localparam logic [3:0] ALU_SUB    = 4'd6;
    localparam logic [3:0] ALU_AND    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_XOR    = 4'd9;

    localparam logic [1:0] MUXA_IMM  = 2'd0;
    localparam logic [1:0] MUXA_MEM  = 2'd1;
    localparam logic [1:0] MUXA_ARFC = 2'd2;
    localparam logic [1:0] MUXA_ALU  = 2'd3;

    localparam logic [1:0] MUXB_IMM = 2'd1;
    localparam logic [1:0] MUXB_MEM = 2'd2;
    localparam logic [1:0] MUXB_ALU = 2'd3;

    localparam logic MUXC_ARF = 1'b0;
    localparam logic MUXC_RF  = 1'b1;

    localparam logic [1:0] ARF_SEL_PC = 2'd0;
    localparam logic [1:0] ARF_SEL_AR = 2'd2;
    localparam logic [1:0] ARF_SEL_SP = 2'd3;

    // ARF enables are active-low: bit0 PC, bit1 AR, bit2 SP.
    localparam logic [2:0] ARF_EN_NONE = 3'b111;
    localparam logic [2:0] ARF_EN_ALL  = 3'b000;
    localparam logic [2:0] ARF_EN_PC   = 3'b110;
    localparam logic [2:0] ARF_EN_AR   = 3'b101;

    typedef struct packed {
        logic [1:0] rf_out_a_sel;
        logic [1:0] rf_out_b_sel;
        logic [1:0] rf_fun_sel;
        logic [3:0] rf_reg_sel;
        logic [3:0] alu_fun_sel;
        logic [1:0] arf_out_c_sel;
        logic [1:0] arf_out_d_sel;
        logic [1:0] arf_fun_sel;
        logic [2:0] arf_reg_sel;
        logic       ir_lh;
        logic       ir_enable;
        logic [1:0] ir_fun_sel;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] mux_a_sel;
        logic [1:0] mux_b_sel;
        logic       mux_c_sel;
        logic       halted;
    } ctrl_word_t;

    localparam ctrl_word_t IDLE_WORD = '{
        rf_out_a_sel:  2'd0,
        rf_out_b_sel:  2'd0,
        rf_fun_sel:    2'd0,
        rf_reg_sel:    4'hF,
        alu_fun_sel:   4'd0,
        arf_out_c_sel: 2'd0,
        arf_out_d_sel: 2'd0,
        arf_fun_sel:   2'd0,
        arf_reg_sel:   3'h7,
        ir_lh:         1'b0,
        ir_enable:     1'b0,
        ir_fun_sel:    2'd0,
        mem_wr:        1'b0,
        mem_cs:        1'b1,
        mux_a_sel:     2'd0,
        mux_b_sel:     2'd0,
        mux_c_sel:     1'b0,
        halted:        1'b0
    };

    // One-cold RF enable for register index 0..3 (R1..R4).
    function automatic logic [3:0] rf_enable(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    function automatic logic is_flag_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_NOT);
    endfunction

    function automatic logic [3:0] alu_code(input logic [3:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_XOR:  return ALU_XOR;
            OP_NOT:  return ALU_NOT_A;
            default: return ALU_PASS_A;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control map: current state, instruction control byte and
// latched flags to the full datapath control word.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [7:0] ir_ctrl,
    input  logic [3:0] flags,
    output ctrl_word_t ctrl
);

    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;

    assign op = ir_ctrl[7:4];
    assign rd = ir_ctrl[3:2];
    assign rs = ir_ctrl[1:0];

    always_comb begin
        ctrl = IDLE_WORD;
        unique case (state)
            INIT: begin
                ctrl.rf_fun_sel  = FUN_CLEAR;
                ctrl.rf_reg_sel  = 4'h0;
                ctrl.arf_fun_sel = FUN_CLEAR;
                ctrl.arf_reg_sel = ARF_EN_ALL;
                ctrl.ir_enable   = 1'b1;
                ctrl.ir_fun_sel  = FUN_CLEAR;
            end
            FETCH_H, FETCH_L: begin
                ctrl.arf_out_d_sel = ARF_SEL_PC;
                ctrl.mem_cs        = 1'b0;
                ctrl.ir_enable     = 1'b1;
                ctrl.ir_fun_sel    = FUN_LOAD;
                ctrl.ir_lh         = (state == FETCH_L);
                ctrl.arf_fun_sel   = FUN_INC;
                ctrl.arf_reg_sel   = ARF_EN_PC;
            end
            EXEC1: begin
                case (op)
                    OP_LDI: begin
                        ctrl.mux_a_sel  = MUXA_IMM;
                        ctrl.rf_fun_sel = FUN_LOAD;
                        ctrl.rf_reg_sel = rf_enable(rd);
                    end
                    OP_LD, OP_ST: begin
                        ctrl.mux_b_sel   = MUXB_IMM;
                        ctrl.arf_fun_sel = FUN_LOAD;
                        ctrl.arf_reg_sel = ARF_EN_AR;
                    end
                    OP_MOV: begin
                        ctrl.rf_out_b_sel = rs;
                        ctrl.alu_fun_sel  = ALU_PASS_B;
                        ctrl.mux_a_sel    = MUXA_ALU;
                        ctrl.rf_fun_sel   = FUN_LOAD;
                        ctrl.rf_reg_sel   = rf_enable(rd);
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                        ctrl.rf_out_a_sel = rd;
                        ctrl.rf_out_b_sel = rs;
                        ctrl.mux_c_sel    = MUXC_RF;
                        ctrl.alu_fun_sel  = alu_code(op);
                        ctrl.mux_a_sel    = MUXA_ALU;
                        ctrl.rf_fun_sel   = FUN_LOAD;
                        ctrl.rf_reg_sel   = rf_enable(rd);
                    end
                    OP_INC, OP_DEC: begin
                        ctrl.rf_fun_sel = (op == OP_INC) ? FUN_INC : FUN_DEC;
                        ctrl.rf_reg_sel = rf_enable(rd);
                    end
                    OP_BRA, OP_BEQ, OP_BNE: begin
                        // Conditional branches fall back to the idle word when not taken.
                        if ((op == OP_BRA) || ((op == OP_BEQ) && flags[0])
                            || ((op == OP_BNE) && !flags[0])) begin
                            ctrl.mux_b_sel   = MUXB_IMM;
                            ctrl.arf_fun_sel = FUN_LOAD;
                            ctrl.arf_reg_sel = ARF_EN_PC;
                        end
                    end
                    default: ;
                endcase
            end
            EXEC2: begin
                if (op == OP_LD) begin
                    ctrl.arf_out_d_sel = ARF_SEL_AR;
                    ctrl.mem_cs        = 1'b0;
                    ctrl.mux_a_sel     = MUXA_MEM;
                    ctrl.rf_fun_sel    = FUN_LOAD;
                    ctrl.rf_reg_sel    = rf_enable(rd);
                end else if (op == OP_ST) begin
                    ctrl.arf_out_d_sel = ARF_SEL_AR;
                    ctrl.rf_out_a_sel  = rd;
                    ctrl.mux_c_sel     = MUXC_RF;
                    ctrl.alu_fun_sel   = ALU_PASS_A;
                    ctrl.mem_cs        = 1'b0;
                    ctrl.mem_wr        = 1'b1;
                end
            end
            HALT: ctrl.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired control unit for the 8-bit datapath: holds the state and flag
// registers and drives every datapath control input through ctrl_decode.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IR_W   = 16
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [IR_W-1:0] IR_In,
    input  logic [3:0]      ALU_Flag,
    output logic [1:0]      RF_OutASel,
    output logic [1:0]      RF_OutBSel,
    output logic [1:0]      RF_FunSel,
    output logic [3:0]      RF_RegSel,
    output logic [3:0]      ALU_FunSel,
    output logic [1:0]      ARF_OutCSel,
    output logic [1:0]      ARF_OutDSel,
    output logic [1:0]      ARF_FunSel,
    output logic [2:0]      ARF_RegSel,
    output logic            IR_LH,
    output logic            IR_Enable,
    output logic [1:0]      IR_FunSel,
    output logic            Mem_WR,
    output logic            Mem_CS,
    output logic [1:0]      MuxASel,
    output logic [1:0]      MuxBSel,
    output logic            MuxCSel,
    output logic [3:0]      Flags,
    output logic [2:0]      State,
    output logic            Halted
);

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic [7:0] ir_ctrl;
    logic [3:0] opcode;
    ctrl_word_t ctrl;
    logic       unused_imm;

    assign ir_ctrl    = IR_In[IR_W-1:DATA_W];
    assign opcode     = ir_ctrl[7:4];
    assign unused_imm = ^IR_In[DATA_W-1:0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= INIT;
            flags_q <= 4'h0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT:    state_d = FETCH_H;
            FETCH_H: state_d = FETCH_L;
            FETCH_L: state_d = EXEC1;
            EXEC1: begin
                if ((opcode == OP_LD) || (opcode == OP_ST)) state_d = EXEC2;
                else if (opcode == OP_HLT)                  state_d = HALT;
                else                                        state_d = FETCH_H;
            end
            EXEC2:   state_d = FETCH_H;
            HALT:    state_d = HALT;
            default: state_d = INIT;
        endcase
    end

    // Flags latch on the same edge as the Rd write, so a following branch sees them.
    always_comb begin
        flags_d = flags_q;
        if ((state_q == EXEC1) && is_flag_op(opcode)) flags_d = ALU_Flag;
    end

    ctrl_decode u_decode (
        .state   (state_q),
        .ir_ctrl (ir_ctrl),
        .flags   (flags_q),
        .ctrl    (ctrl)
    );

    assign RF_OutASel  = ctrl.rf_out_a_sel;
    assign RF_OutBSel  = ctrl.rf_out_b_sel;
    assign RF_FunSel   = ctrl.rf_fun_sel;
    assign RF_RegSel   = ctrl.rf_reg_sel;
    assign ALU_FunSel  = ctrl.alu_fun_sel;
    assign ARF_OutCSel = ctrl.arf_out_c_sel;
    assign ARF_OutDSel = ctrl.arf_out_d_sel;
    assign ARF_FunSel  = ctrl.arf_fun_sel;
    assign ARF_RegSel  = ctrl.arf_reg_sel;
    assign IR_LH       = ctrl.ir_lh;
    assign IR_Enable   = ctrl.ir_enable;
    assign IR_FunSel   = ctrl.ir_fun_sel;
    // Memory is deselected the instant reset falls, aborting any in-flight store.
    assign Mem_WR      = ctrl.mem_wr & RST_N;
    assign Mem_CS      = ctrl.mem_cs | ~RST_N;
    assign MuxASel     = ctrl.mux_a_sel;
    assign MuxBSel     = ctrl.mux_b_sel;
    assign MuxCSel     = ctrl.mux_c_sel;
    assign Flags       = flags_q;
    assign State       = state_q;
    assign Halted      = ctrl.halted;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: a behavioural datapath (RF, ARF, IR, ALU, memory) is
// driven by the DUT's controls and compared against an instruction-level model.
module tb_ctrl_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] IR_In;
    logic [3:0]  ALU_Flag;
    logic [1:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
    logic [3:0]  RF_RegSel, ALU_FunSel;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
    logic [2:0]  ARF_RegSel;
    logic        IR_LH, IR_Enable;
    logic [1:0]  IR_FunSel;
    logic        Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel;
    logic [3:0]  Flags;
    logic [2:0]  State;
    logic        Halted;

    int err_count = 0;
    int check_count = 0;

    // Datapath model, driven only by the DUT's control outputs.
    logic [7:0]  rf [4];
    logic [7:0]  pc, ar, sp;
    logic [15:0] ir_reg;
    logic [7:0]  mem [256];
    logic [7:0]  arf_c, alu_a, alu_b, alu_out;

    // Instruction-level reference model.
    logic [7:0]  isa_mem [256];
    logic [7:0]  isa_r [4];
    logic [7:0]  isa_pc, isa_ar;
    logic [3:0]  isa_flags;
    logic        isa_halted;

    ctrl_sequencer #(.DATA_W(8), .IR_W(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .IR_In(IR_In), .ALU_Flag(ALU_Flag),
        .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
        .RF_RegSel(RF_RegSel), .ALU_FunSel(ALU_FunSel), .ARF_OutCSel(ARF_OutCSel),
        .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
        .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_FunSel(IR_FunSel),
        .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel),
        .MuxCSel(MuxCSel), .Flags(Flags), .State(State), .Halted(Halted)
    );

    always #5 CLK = ~CLK;

    assign IR_In = ir_reg;

    // ALU result is {O,N,C,Z, result}; C on SUB means no borrow.
    function automatic logic [11:0] aluCalc(input logic [3:0] fun, input logic [7:0] a,
                                            input logic [7:0] b);
        logic [8:0] wide;
        logic [7:0] r;
        logic       c, o;
        c = 1'b0;
        o = 1'b0;
        wide = 9'd0;
        case (fun)
            4'd0: r = a;
            4'd1: r = b;
            4'd2: r = ~a;
            4'd4: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[7:0];
                c = wide[8];
                o = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'd6: begin
                wide = {1'b0, a} + {1'b0, ~b} + 9'd1;
                r = wide[7:0];
                c = wide[8];
                o = (a[7] != b[7]) && (r[7] != a[7]);
            end
            4'd7: r = a & b;
            4'd8: r = a | b;
            4'd9: r = a ^ b;
            default: r = 8'd0;
        endcase
        return {o, r[7], c, (r == 8'd0), r};
    endfunction

    function automatic logic [7:0] regFun(input logic [7:0] cur, input logic [1:0] fun,
                                          input logic [7:0] din);
        case (fun)
            2'd0: return cur - 8'd1;
            2'd1: return cur + 8'd1;
            2'd2: return din;
            default: return 8'd0;
        endcase
    endfunction

    always_comb begin
        arf_c = (ARF_OutCSel == 2'd2) ? ar : (ARF_OutCSel == 2'd3) ? sp : pc;
        alu_a = MuxCSel ? rf[RF_OutASel] : arf_c;
        alu_b = rf[RF_OutBSel];
        {ALU_Flag, alu_out} = aluCalc(ALU_FunSel, alu_a, alu_b);
    end

    task automatic checkOutput(input string tag, input logic [15:0] got,
                               input logic [15:0] exp);
        check_count++;
        if (got !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: sample controls before the edge, update the datapath after it.
    task automatic tickClock();
        logic [7:0] addr, mem_data, rf_in, arf_in, alu_snap;
        logic [1:0] rf_fun, arf_fun, ir_fun;
        logic [3:0] rf_en;
        logic [2:0] arf_en;
        logic       ir_en, ir_lh, mem_write;
        addr = (ARF_OutDSel == 2'd2) ? ar : (ARF_OutDSel == 2'd3) ? sp : pc;
        mem_data = mem[addr];
        case (MuxASel)
            2'd0: rf_in = ir_reg[7:0];
            2'd1: rf_in = mem_data;
            2'd2: rf_in = arf_c;
            default: rf_in = alu_out;
        endcase
        case (MuxBSel)
            2'd1: arf_in = ir_reg[7:0];
            2'd2: arf_in = mem_data;
            2'd3: arf_in = alu_out;
            default: arf_in = 8'd0;
        endcase
        alu_snap = alu_out;
        rf_fun = RF_FunSel;
        rf_en = RF_RegSel;
        arf_fun = ARF_FunSel;
        arf_en = ARF_RegSel;
        ir_en = IR_Enable;
        ir_fun = IR_FunSel;
        ir_lh = IR_LH;
        mem_write = !Mem_CS && Mem_WR;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 4; i++)
            if (!rf_en[i]) rf[i] = regFun(rf[i], rf_fun, rf_in);
        if (!arf_en[0]) pc = regFun(pc, arf_fun, arf_in);
        if (!arf_en[1]) ar = regFun(ar, arf_fun, arf_in);
        if (!arf_en[2]) sp = regFun(sp, arf_fun, arf_in);
        if (ir_en) begin
            case (ir_fun)
                2'd2: if (ir_lh) ir_reg[7:0] = mem_data; else ir_reg[15:8] = mem_data;
                2'd3: ir_reg = 16'd0;
                2'd1: ir_reg = ir_reg + 16'd1;
                default: ir_reg = ir_reg - 16'd1;
            endcase
        end
        if (mem_write) mem[addr] = alu_snap;
    endtask

    task automatic isaStep(output int cycles, output logic branch_idle);
        logic [7:0] op_byte, imm, nxt;
        logic [3:0] op;
        logic [1:0] rd, rs;
        logic [11:0] res;
        op_byte = isa_mem[isa_pc];
        nxt = isa_pc + 8'd1;
        imm = isa_mem[nxt];
        op = op_byte[7:4];
        rd = op_byte[3:2];
        rs = op_byte[1:0];
        isa_pc = isa_pc + 8'd2;
        cycles = 3;
        branch_idle = 1'b0;
        case (op)
            4'h0: isa_r[rd] = imm;
            4'h1: begin isa_ar = imm; isa_r[rd] = isa_mem[imm]; cycles = 4; end
            4'h2: begin isa_ar = imm; isa_mem[imm] = isa_r[rd]; cycles = 4; end
            4'h3: isa_r[rd] = isa_r[rs];
            4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
                case (op)
                    4'h4: res = aluCalc(4'd4, isa_r[rd], isa_r[rs]);
                    4'h5: res = aluCalc(4'd6, isa_r[rd], isa_r[rs]);
                    4'h6: res = aluCalc(4'd7, isa_r[rd], isa_r[rs]);
                    4'h7: res = aluCalc(4'd8, isa_r[rd], isa_r[rs]);
                    4'h8: res = aluCalc(4'd9, isa_r[rd], isa_r[rs]);
                    default: res = aluCalc(4'd2, isa_r[rd], isa_r[rs]);
                endcase
                isa_r[rd] = res[7:0];
                isa_flags = res[11:8];
            end
            4'hA: isa_r[rd] = isa_r[rd] + 8'd1;
            4'hB: isa_r[rd] = isa_r[rd] - 8'd1;
            4'hC: isa_pc = imm;
            4'hD: if (isa_flags[0]) isa_pc = imm; else branch_idle = 1'b1;
            4'hE: if (!isa_flags[0]) isa_pc = imm; else branch_idle = 1'b1;
            default: isa_halted = 1'b1;
        endcase
    endtask

    // Run one instruction (or one halted cycle) and compare architectural state.
    task automatic applyStimulus();
        int cycles, diffs;
        logic branch_idle;
        if (isa_halted) begin
            checkOutput("haltState", 16'(State), 16'd5);
            checkOutput("haltFlag", 16'(Halted), 16'd1);
            checkOutput("haltMemCs", 16'(Mem_CS), 16'd1);
            checkOutput("haltRfEn", 16'(RF_RegSel), 16'hF);
            checkOutput("haltArfEn", 16'(ARF_RegSel), 16'h7);
            checkOutput("haltIrEn", 16'(IR_Enable), 16'd0);
            tickClock();
            return;
        end
        isaStep(cycles, branch_idle);
        checkOutput("fetchHState", 16'(State), 16'd1);
        checkOutput("notHalted", 16'(Halted), 16'd0);
        tickClock();
        checkOutput("fetchLState", 16'(State), 16'd2);
        tickClock();
        checkOutput("exec1State", 16'(State), 16'd3);
        checkOutput("exec1MemCs", 16'(Mem_CS), 16'd1);
        if (branch_idle) checkOutput("branchIdleArf", 16'(ARF_RegSel), 16'h7);
        tickClock();
        if (cycles == 4) begin
            checkOutput("exec2State", 16'(State), 16'd4);
            tickClock();
        end
        for (int i = 0; i < 4; i++) checkOutput($sformatf("rf%0d", i), 16'(rf[i]), 16'(isa_r[i]));
        checkOutput("pc", 16'(pc), 16'(isa_pc));
        checkOutput("ar", 16'(ar), 16'(isa_ar));
        checkOutput("flags", 16'(Flags), 16'(isa_flags));
        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== isa_mem[i]) diffs++;
        checkOutput("memImageDiffs", 16'(diffs), 16'd0);
    endtask

    task automatic resetDut();
        RST_N = 1'b0;
        #2;
        checkOutput("rstState", 16'(State), 16'd0);
        checkOutput("rstFlags", 16'(Flags), 16'd0);
        checkOutput("rstMemCs", 16'(Mem_CS), 16'd1);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) isa_r[i] = 8'd0;
        isa_pc = 8'd0;
        isa_ar = 8'd0;
        isa_flags = 4'd0;
        isa_halted = 1'b0;
        tickClock();
    endtask

    task automatic loadByte(input logic [7:0] addr, input logic [7:0] val);
        mem[addr] = val;
        isa_mem[addr] = val;
    endtask

    initial begin
        logic [7:0] b;
        for (int i = 0; i < 4; i++) rf[i] = 8'd0;
        pc = 8'd0; ar = 8'd0; sp = 8'd0; ir_reg = 16'd0;
        for (int i = 0; i < 256; i++) loadByte(8'(i), 8'h00);

        // Directed program: LDI, ADD overflow to zero, branches, ST/LD round trip, HLT.
        loadByte(8'h00, 8'h08); loadByte(8'h01, 8'h5A);
        loadByte(8'h02, 8'h00); loadByte(8'h03, 8'h80);
        loadByte(8'h04, 8'h04); loadByte(8'h05, 8'h80);
        loadByte(8'h06, 8'h41); loadByte(8'h07, 8'h00);
        loadByte(8'h08, 8'hD0); loadByte(8'h09, 8'h20);
        loadByte(8'h20, 8'h00); loadByte(8'h21, 8'h3C);
        loadByte(8'h22, 8'h20); loadByte(8'h23, 8'h40);
        loadByte(8'h24, 8'h1C); loadByte(8'h25, 8'h40);
        loadByte(8'h26, 8'h44); loadByte(8'h27, 8'h00);
        loadByte(8'h28, 8'hD0); loadByte(8'h29, 8'h50);
        loadByte(8'h2A, 8'hE0); loadByte(8'h2B, 8'h30);
        loadByte(8'h30, 8'hF0); loadByte(8'h31, 8'h00);
        resetDut();
        applyStimulus();
        checkOutput("ldiR3", 16'(rf[2]), 16'h5A);
        checkOutput("ldiPc", 16'(pc), 16'h02);
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("addR1", 16'(rf[0]), 16'h00);
        checkOutput("addZ", 16'(Flags[0]), 16'd1);
        checkOutput("addC", 16'(Flags[1]), 16'd1);
        applyStimulus();
        checkOutput("beqTaken", 16'(pc), 16'h20);
        applyStimulus();
        applyStimulus();
        checkOutput("stMem", 16'(mem[8'h40]), 16'h3C);
        applyStimulus();
        checkOutput("ldR4", 16'(rf[3]), 16'h3C);
        applyStimulus();
        applyStimulus();
        checkOutput("beqNotTaken", 16'(pc), 16'h2A);
        applyStimulus();
        checkOutput("bneTaken", 16'(pc), 16'h30);
        applyStimulus();
        for (int i = 0; i < 12; i++) applyStimulus();

        // Reset while a store sits in EXEC2: memory must never see the write.
        loadByte(8'h00, 8'h20); loadByte(8'h01, 8'h40); loadByte(8'h40, 8'hAB);
        resetDut();
        tickClock();
        tickClock();
        tickClock();
        checkOutput("stExec2State", 16'(State), 16'd4);
        checkOutput("stExec2Cs", 16'(Mem_CS), 16'd0);
        RST_N = 1'b0;
        #1;
        checkOutput("rstAbortCs", 16'(Mem_CS), 16'd1);
        checkOutput("rstAbortWr", 16'(Mem_WR), 16'd0);
        checkOutput("rstAbortState", 16'(State), 16'd0);
        tickClock();
        RST_N = 1'b1;
        checkOutput("rstInitState", 16'(State), 16'd0);
        tickClock();
        checkOutput("rstFetchState", 16'(State), 16'd1);
        checkOutput("rstFetchAddr", 16'(ARF_OutDSel), 16'd0);
        checkOutput("rstFetchCs", 16'(Mem_CS), 16'd0);
        checkOutput("noPartialWrite", 16'(mem[8'h40]), 16'hAB);

        // Random programs; HLT is kept rare so most runs execute many instructions.
        for (int run = 0; run < 4; run++) begin
            for (int i = 0; i < 256; i++) begin
                b = {4'($urandom_range(0, 14)), 4'($urandom)};
                loadByte(8'(i), b);
            end
            if (run == 3) begin loadByte(8'h10, 8'hF0); loadByte(8'h00, 8'hC0); loadByte(8'h01, 8'h10); end
            resetDut();
            for (int n = 0; n < 150; n++) applyStimulus();
        end

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
